// File: rtl/common_pkg.sv
// Common scalar typedefs shared across the pipeline.
package common_pkg;

  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

endpackage : common_pkg

// File: rtl/instr_fetch_pkg.sv
// Pipeline types for the fetch stage: FSM state encoding, the
// fetch-to-decode bundle and the NOP instruction constant.
package instr_fetch_pkg;

  import common_pkg::*;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic valid;
    u64   pc;
    u32   raw_instr;
    logic misalign;
  } fetch_bundle_t;

  // addi x0, x0, 0
  localparam u32 NOP_INSTR = 32'h0000_0013;

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one instruction-bus request at a time,
// holds the returned word for decode, and handles redirects with priority
// over every other event (squashing or dropping in-flight data).
// Optional feature macro: FETCH_MISALIGN_EXC_EN -- when defined, a misaligned
// pc is not fetched but delivered to decode as a NOP flagged out_misalign;
// when undefined, redirect targets are forced word-aligned and out_misalign
// is always 0.
module instr_fetch
  import common_pkg::*;
  import instr_fetch_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_raw_instr,
  output logic        out_misalign
);

  fetch_state_t  state_q, state_d;
  u64            pc_q, pc_d;
  fetch_bundle_t out_q, out_d;
  logic          pc_misaligned;

`ifdef FETCH_MISALIGN_EXC_EN
  // Misaligned targets are kept so they can be reported to decode.
  function automatic u64 redirect_target(input u64 rpc);
    return rpc;
  endfunction

  assign pc_misaligned = (pc_q[1:0] != 2'b00);
`else
  // Without misalignment reporting the low bits are simply dropped.
  function automatic u64 redirect_target(input u64 rpc);
    return {rpc[63:2], 2'b00};
  endfunction

  assign pc_misaligned = 1'b0;
`endif

  // State, pc and decode-facing registers; reset abandons any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
    end
  end

  // Next-state, pc update, capture and bus request; redirect wins everywhere.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_d      = out_q;
    ireq_valid = 1'b0;
    ireq_addr  = '0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) begin
          pc_d = redirect_target(redirect_pc);
        end
      end

      REQ: begin
        if (pc_misaligned) begin
          // No bus request for a misaligned pc; hand decode a flagged NOP.
          if (redirect_valid) begin
            pc_d = redirect_target(redirect_pc);
          end else begin
            out_d = '{valid: 1'b1, pc: pc_q, raw_instr: NOP_INSTR, misalign: 1'b1};
            state_d = HOLD;
          end
        end else begin
          ireq_valid = 1'b1;
          ireq_addr  = pc_q;
          if (redirect_valid) begin
            pc_d = redirect_target(redirect_pc);
            // An accepted request whose data has not yet returned must be drained.
            if (iresp_addr_ok && !iresp_data_ok) begin
              state_d = DROP;
            end
          end else if (iresp_addr_ok && iresp_data_ok) begin
            out_d   = '{valid: 1'b1, pc: pc_q, raw_instr: iresp_data, misalign: 1'b0};
            state_d = HOLD;
          end else if (iresp_addr_ok) begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_target(redirect_pc);
          state_d = iresp_data_ok ? REQ : DROP;
        end else if (iresp_data_ok) begin
          out_d   = '{valid: 1'b1, pc: pc_q, raw_instr: iresp_data, misalign: 1'b0};
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          out_d.valid    = 1'b0;
          out_d.misalign = 1'b0;
          pc_d           = redirect_target(redirect_pc);
          state_d        = REQ;
        end else if (out_ready) begin
          out_d.valid    = 1'b0;
          out_d.misalign = 1'b0;
          pc_d           = pc_q + 64'd4;
          state_d        = REQ;
        end
      end

      DROP: begin
        if (redirect_valid) begin
          pc_d = redirect_target(redirect_pc);
        end
        if (iresp_data_ok) begin
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_valid     = out_q.valid;
  assign out_pc        = out_q.pc;
  assign out_raw_instr = out_q.raw_instr;
  assign out_misalign  = out_q.misalign;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_raw_instr;
  logic        out_misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_addr_ok (iresp_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_raw_instr (out_raw_instr),
    .out_misalign  (out_misalign)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic aok, input logic dok, input logic [31:0] data,
                       input logic rv, input logic [63:0] rpc, input logic rdy);
    iresp_addr_ok  = aok;
    iresp_data_ok  = dok;
    iresp_data     = data;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ireq_valid"}, 64'(ireq_valid), 64'd0);
    chk({tag, "_ireq_addr"}, ireq_addr, 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_pc"}, out_pc, 64'd0);
    chk({tag, "_out_raw"}, 64'(out_raw_instr), 64'd0);
    chk({tag, "_out_misalign"}, 64'(out_misalign), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        aok;
    logic        dok;
    logic [31:0] data;
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        e_iv;
    logic [63:0] e_ia;
    logic        e_ov;
    logic [63:0] e_pc;
    logic [31:0] e_raw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic aok, logic dok, logic [31:0] data, logic rv,
                              logic [63:0] rpc, logic rdy, logic e_iv, logic [63:0] e_ia,
                              logic e_ov, logic [63:0] e_pc, logic [31:0] e_raw);
    vec_t v;
    v.aok = aok; v.dok = dok; v.data = data; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_iv = e_iv; v.e_ia = e_ia; v.e_ov = e_ov; v.e_pc = e_pc; v.e_raw = e_raw;
    return v;
  endfunction

  // ---------------- reference model ----------------
  bit          m_started, m_outst, m_discard, m_held, m_hmis;
  logic [63:0] m_pc, m_hpc;
  logic [31:0] m_hraw;

  function automatic bit mis_en();
`ifdef FETCH_MISALIGN_EXC_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] tgt(input logic [63:0] r);
    logic [63:0] t;
    t = r;
    if (!mis_en()) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic model_reset();
    m_started = 0; m_outst = 0; m_discard = 0; m_held = 0; m_hmis = 0;
    m_pc = 64'h0000_0000_8000_0000; m_hpc = '0; m_hraw = '0;
  endtask

  task automatic model_capture(input logic [31:0] w, input bit mis);
    m_held = 1; m_hpc = m_pc; m_hraw = w; m_hmis = mis;
  endtask

  task automatic model_step();
    if (!m_started) begin
      m_started = 1;
      if (redirect_valid) m_pc = tgt(redirect_pc);
    end else if (m_held) begin
      if (redirect_valid) begin
        m_held = 0; m_pc = tgt(redirect_pc);
      end else if (out_ready) begin
        m_held = 0; m_pc = m_pc + 64'd4;
      end
    end else if (m_outst) begin
      if (iresp_data_ok) begin
        m_outst = 0;
        if (!m_discard && !redirect_valid) model_capture(iresp_data, 0);
      end else if (redirect_valid) begin
        m_discard = 1;
      end
      if (redirect_valid) m_pc = tgt(redirect_pc);
    end else if (mis_en() && m_pc[1:0] != 2'b00) begin
      if (redirect_valid) m_pc = tgt(redirect_pc);
      else model_capture(32'h0000_0013, 1);
    end else begin
      if (redirect_valid) begin
        if (iresp_addr_ok && !iresp_data_ok) begin
          m_outst = 1; m_discard = 1;
        end
        m_pc = tgt(redirect_pc);
      end else if (iresp_addr_ok && iresp_data_ok) begin
        model_capture(iresp_data, 0);
      end else if (iresp_addr_ok) begin
        m_outst = 1; m_discard = 0;
      end
    end
  endtask

  task automatic model_check();
    logic exp_iv;
    exp_iv = m_started && !m_outst && !m_held && !(mis_en() && m_pc[1:0] != 2'b00);
    chk("rnd_ireq_valid", 64'(ireq_valid), 64'(exp_iv));
    chk("rnd_ireq_addr", ireq_addr, exp_iv ? m_pc : 64'd0);
    chk("rnd_out_valid", 64'(out_valid), 64'(m_held));
    chk("rnd_out_misalign", 64'(out_misalign), 64'(m_held & m_hmis));
    if (m_held) begin
      chk("rnd_out_pc", out_pc, m_hpc);
      chk("rnd_out_raw", 64'(out_raw_instr), 64'(m_hraw));
    end
  endtask

  initial begin
    logic [63:0] rpc;
    idle_inputs();
    reset = 1'b1;

    // Reset state.
    #12;
    chk_all_zero("reset");

    // Vector table, one row per cycle starting in IDLE.
    tbl.push_back(mk(0,0,32'h0,0,64'h0,0,        0,64'h0,0,64'h0,32'h0));
    tbl.push_back(mk(1,1,32'h00A00093,0,64'h0,0, 1,64'h80000000,0,64'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,64'h0,1,        0,64'h0,1,64'h80000000,32'h00A00093));
    tbl.push_back(mk(1,0,32'h0,0,64'h0,0,        1,64'h80000004,0,64'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,64'h0,0,        0,64'h0,0,64'h0,32'h0));
    tbl.push_back(mk(0,1,32'h11111111,0,64'h0,0, 0,64'h0,0,64'h0,32'h0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,32'h0,0,64'h0,0,      0,64'h0,1,64'h80000004,32'h11111111));
    tbl.push_back(mk(0,0,32'h0,0,64'h0,1,        0,64'h0,1,64'h80000004,32'h11111111));
    tbl.push_back(mk(1,0,32'h0,0,64'h0,0,        1,64'h80000008,0,64'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,64'h80001000,0, 0,64'h0,0,64'h0,32'h0));
    tbl.push_back(mk(0,1,32'hDEADBEEF,0,64'h0,0, 0,64'h0,0,64'h0,32'h0));
    tbl.push_back(mk(1,1,32'h22222222,0,64'h0,0, 1,64'h80001000,0,64'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,64'h0,0,        0,64'h0,1,64'h80001000,32'h22222222));
    tbl.push_back(mk(0,0,32'h0,1,64'h80000010,1, 0,64'h0,1,64'h80001000,32'h22222222));
    tbl.push_back(mk(1,1,32'h33333333,0,64'h0,0, 1,64'h80000010,0,64'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,64'h80002000,1, 0,64'h0,1,64'h80000010,32'h33333333));
    tbl.push_back(mk(0,0,32'h0,1,64'h80003000,0, 1,64'h80002000,0,64'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,64'h0,0,        1,64'h80003000,0,64'h0,32'h0));
    tbl.push_back(mk(1,0,32'h0,0,64'h0,0,        1,64'h80003000,0,64'h0,32'h0));
    tbl.push_back(mk(0,1,32'h44444444,1,64'h80004000,0, 0,64'h0,0,64'h0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,64'h80005000,0, 1,64'h80004000,0,64'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,64'h80006000,0, 0,64'h0,0,64'h0,32'h0));
    tbl.push_back(mk(0,1,32'h55555555,0,64'h0,0, 0,64'h0,0,64'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,64'h0,0,        1,64'h80006000,0,64'h0,32'h0));
    tbl.push_back(mk(1,1,32'h66666666,0,64'h0,0, 1,64'h80006000,0,64'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,64'h0,1,        0,64'h0,1,64'h80006000,32'h66666666));
    tbl.push_back(mk(0,0,32'h0,0,64'h0,0,        1,64'h80006004,0,64'h0,32'h0));

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].aok, tbl[i].dok, tbl[i].data, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      #1;
      chk($sformatf("vec%0d_ireq_valid", i), 64'(ireq_valid), 64'(tbl[i].e_iv));
      chk($sformatf("vec%0d_ireq_addr", i), ireq_addr, tbl[i].e_ia);
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("vec%0d_out_misalign", i), 64'(out_misalign), 64'd0);
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc, tbl[i].e_pc);
        chk($sformatf("vec%0d_out_raw", i), 64'(out_raw_instr), 64'(tbl[i].e_raw));
      end
      @(negedge clk);
    end

    // Misaligned redirect target (state is REQ here).
    drive(0, 0, 32'h0, 1, 64'h8000_0002, 0);
    @(negedge clk);
    idle_inputs();
    #1;
`ifdef FETCH_MISALIGN_EXC_EN
    chk("mis_no_req", 64'(ireq_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("mis_out_valid", 64'(out_valid), 64'd1);
    chk("mis_flag", 64'(out_misalign), 64'd1);
    chk("mis_raw_nop", 64'(out_raw_instr), 64'h13);
    chk("mis_out_pc", out_pc, 64'h8000_0002);
    chk("mis_hold_no_req", 64'(ireq_valid), 64'd0);
`else
    chk("mis_req_valid", 64'(ireq_valid), 64'd1);
    chk("mis_req_aligned", ireq_addr, 64'h8000_0000);
    chk("mis_flag_zero", 64'(out_misalign), 64'd0);
`endif
    drive(0, 0, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("wrap_req_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1, 1, 32'h77777777, 0, 64'h0, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 64'h0, 1);
    #1;
    chk("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("wrap_valid", 64'(ireq_valid), 64'd1);
    chk("wrap_next_addr", ireq_addr, 64'd0);

    // Reset asserted while waiting for data; stale response must be ignored.
    drive(1, 0, 32'h0, 0, 64'h0, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rst_wait_state", 64'(ireq_valid), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    drive(0, 1, 32'hBADBAD00, 0, 64'h0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("stale_req_valid", 64'(ireq_valid), 64'd1);
    chk("stale_req_addr", ireq_addr, 64'h8000_0000);
    chk("stale_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("stale_out_valid2", 64'(out_valid), 64'd0);
    chk("stale_raw", 64'(out_raw_instr), 64'd0);

    // Randomized traffic against the model.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rpc = {32'h0, 32'h8000_0000 | ($urandom_range(0, 255) << 2)};
      if ($urandom_range(0, 9) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4), $urandom,
            1'($urandom_range(0, 9) == 0), rpc, 1'($urandom_range(0, 1)));
      #1;
      model_check();
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch
